spi_serializer: RTL and testbench

SPI write-only serializer for the front-end control path: it shifts a 24-bit control word to one of two daisy-less SPI slaves, either an attenuator or a delay line. On a load request it captures `Data_Register[23:0]` and the target select, then drives SPI clock, data and the selected active-low chip-select for one complete transfer. The block sits between the register/control logic and the board-level attenuator and delay-line pins.

---
 rtl/spi_serializer.sv | 155 +++++++++++++++
 tb/tb_spi_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_serializer.sv
// Write-only SPI serializer: on a rising ld it captures an NBITS control word
// and shifts it MSB first (mode 0) to the attenuator or the delay line.
module spi_serializer #(
  parameter int CLK_DIV = 4,
  parameter int NBITS   = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Data_Register,
  input  logic        ld,
  input  logic [1:0]  DelAttSelect,
  output logic        DataBit,
  output logic        SPI_clk,
  output logic        Att_CS,
  output logic        Del_CS,
  output logic [1:0]  dbg_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             ld_q, ld_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             data_bit_q, data_bit_d;
  logic             spi_clk_q, spi_clk_d;
  logic             att_cs_q, att_cs_d;
  logic             del_cs_q, del_cs_d;

  logic             div_end;
  logic             sel_valid;
  logic             start;
  logic [NBITS-1:0] shift_next;

  generate
    if (NBITS < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^Data_Register[31:NBITS];
    end
  endgenerate

  assign div_end    = (div_q == DIV_LAST);
  assign sel_valid  = (DelAttSelect == 2'b01) || (DelAttSelect == 2'b10);
  assign start      = ld && !ld_q && (state_q == S_IDLE) && sel_valid;
  assign shift_next = shift_q << 1;

  always_comb begin
    state_d    = state_q;
    ld_d       = ld;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    data_bit_d = data_bit_q;
    spi_clk_d  = spi_clk_q;
    att_cs_d   = att_cs_q;
    del_cs_d   = del_cs_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d    = Data_Register[NBITS-1:0];
          bit_cnt_d  = CNT_W'(NBITS);
          div_d      = '0;
          data_bit_d = Data_Register[NBITS-1];
          spi_clk_d  = 1'b0;
          att_cs_d   = (DelAttSelect != 2'b01);
          del_cs_d   = (DelAttSelect != 2'b10);
          state_d    = S_LOW;
        end
      end
      S_LOW: begin
        if (div_end) begin
          div_d     = '0;
          spi_clk_d = 1'b1;
          state_d   = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          div_d     = '0;
          spi_clk_d = 1'b0;
          if (bit_cnt_q == CNT_W'(1)) begin
            bit_cnt_d = '0;
            state_d   = S_TAIL;
          end else begin
            // Data moves on the falling SPI_clk edge only, keeping mode 0.
            shift_d    = shift_next;
            data_bit_d = shift_next[NBITS-1];
            bit_cnt_d  = bit_cnt_q - 1'b1;
            state_d    = S_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_TAIL: begin
        if (div_end) begin
          div_d      = '0;
          data_bit_d = 1'b0;
          att_cs_d   = 1'b1;
          del_cs_d   = 1'b1;
          state_d    = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_q       <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
      data_bit_q <= 1'b0;
      spi_clk_q  <= 1'b0;
      att_cs_q   <= 1'b1;
      del_cs_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      data_bit_q <= data_bit_d;
      spi_clk_q  <= spi_clk_d;
      att_cs_q   <= att_cs_d;
      del_cs_q   <= del_cs_d;
    end
  end

  assign DataBit   = data_bit_q;
  assign SPI_clk   = spi_clk_q;
  assign Att_CS    = att_cs_q;
  assign Del_CS    = del_cs_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_serializer.sv
// Directed and randomized transfers against a bit-level reference of the SPI
// waveform: bits sampled at SPI_clk rises, CS-low spans and rise timing.
module tb_spi_serializer;

  localparam int CD = 4;
  localparam int NB = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Data_Register = '0;
  logic        ld = 1'b0;
  logic [1:0]  DelAttSelect = 2'b00;
  logic        DataBit, SPI_clk, Att_CS, Del_CS;
  logic [1:0]  dbg_state;

  spi_serializer #(.CLK_DIV(CD), .NBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .Data_Register(Data_Register), .ld(ld),
    .DelAttSelect(DelAttSelect), .DataBit(DataBit), .SPI_clk(SPI_clk),
    .Att_CS(Att_CS), .Del_CS(Del_CS), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus monitor (cumulative counters) ----------------
  int   cyc = 0, rises_tot = 0, att_low_tot = 0, del_low_tot = 0, viol_tot = 0;
  logic cap_q[$];
  int   rise_cyc_q[$];
  logic prev_clk = 1'b0, prev_data = 1'b0, prev_cs_low = 1'b0;

  always @(negedge clk) begin
    logic cs_low;
    cs_low = (Att_CS === 1'b0) || (Del_CS === 1'b0);
    cyc++;
    if (prev_clk === 1'b0 && SPI_clk === 1'b1) begin
      rises_tot++;
      cap_q.push_back(DataBit);
      rise_cyc_q.push_back(cyc);
    end
    if (Att_CS === 1'b0) att_low_tot++;
    if (Del_CS === 1'b0) del_low_tot++;
    if ((DataBit !== prev_data) && !(prev_clk === 1'b1 && SPI_clk === 1'b0)
        && prev_cs_low && cs_low)
      viol_tot++;
    prev_clk    = SPI_clk;
    prev_data   = DataBit;
    prev_cs_low = cs_low;
  end

  // ---------------- scoreboard ----------------
  int n_err = 0, n_checks = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: word bits NB-1 down to 0, one per SPI_clk rise.
  task automatic push_expected(input logic [31:0] word);
    for (int k = 0; k < NB; k++) exp_q.push_back(1'((word >> (NB - 1 - k)) & 32'd1));
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_ld(output int c0);
    @(posedge clk); #1 ld = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
    c0 = cyc;
  endtask

  task automatic run_xfer(input string tag, input logic [1:0] sel, input logic [31:0] word,
                          input int chg_at, input int pulse_at);
    int r0, a0, d0, q0, rc0, c0, n, bad;
    logic [31:0] obs_bits, exp_bits;
    r0 = rises_tot; a0 = att_low_tot; d0 = del_low_tot;
    q0 = cap_q.size(); rc0 = rise_cyc_q.size();
    Data_Register = word;
    DelAttSelect  = sel;
    push_expected(word);
    pulse_ld(c0);
    DelAttSelect = 2'($urandom_range(0, 3));
    n = 0;
    while (!(Att_CS === 1'b1 && Del_CS === 1'b1) && n < 400) begin
      @(negedge clk); #1;
      n++;
      if (n == chg_at) Data_Register = 32'h00FF_FFFF;
      if (n == pulse_at) ld = 1'b1;
      if (n == pulse_at + 1) ld = 1'b0;
    end
    chk({tag, "_done"}, 32'(n < 400), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    chk({tag, "_rises"}, 32'(rises_tot - r0), NB);
    chk({tag, "_cs_own"}, 32'(sel == 2'b01 ? att_low_tot - a0 : del_low_tot - d0),
        (2 * NB + 1) * CD);
    chk({tag, "_cs_other"}, 32'(sel == 2'b01 ? del_low_tot - d0 : att_low_tot - a0), 0);
    obs_bits = '0;
    exp_bits = '0;
    for (int k = 0; k < NB; k++) begin
      obs_bits = {obs_bits[30:0], (q0 + k < cap_q.size()) ? cap_q[q0 + k] : 1'bx};
      exp_bits = {exp_bits[30:0], exp_q.pop_front()};
    end
    chk({tag, "_bits"}, obs_bits, exp_bits);
    bad = 0;
    for (int k = 0; k < NB; k++)
      if (rc0 + k >= rise_cyc_q.size() || rise_cyc_q[rc0 + k] != c0 + (2 * k + 1) * CD + 1)
        bad++;
    chk({tag, "_rise_timing"}, 32'(bad), 0);
  endtask

  task automatic check_quiet(input string tag, input int ncyc);
    int r0, a0, d0;
    r0 = rises_tot; a0 = att_low_tot; d0 = del_low_tot;
    repeat (ncyc) @(negedge clk);
    #1;
    chk({tag, "_rises"}, 32'(rises_tot - r0), 0);
    chk({tag, "_cs_low"}, 32'((att_low_tot - a0) + (del_low_tot - d0)), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bad, r0, a0, c0, n;
    logic [31:0] w;

    // Reset held with ld toggling: outputs pinned at 0/0/1/1.
    bad = 0;
    r0 = rises_tot;
    DelAttSelect = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      ld = ~ld;
      if ({DataBit, SPI_clk, Att_CS, Del_CS} !== 4'b0011) bad++;
    end
    ld = 1'b0;
    chk("reset_outputs", 32'(bad), 0);
    chk("reset_rises", 32'(rises_tot - r0), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("post_reset_outputs", {28'd0, DataBit, SPI_clk, Att_CS, Del_CS}, 32'h3);

    run_xfer("att_write", 2'b01, 32'h009E_6D55, -1, -1);
    repeat (120) @(posedge clk);
    run_xfer("del_write", 2'b10, 32'h0080_F0FE, -1, -1);
    run_xfer("data_change", 2'b01, 32'h009E_6D55, 30, -1);

    DelAttSelect = 2'b00;
    pulse_ld(c0);
    check_quiet("sel00", 250);
    DelAttSelect = 2'b11;
    pulse_ld(c0);
    check_quiet("sel11", 250);

    run_xfer("second_ld", 2'b10, 32'h00A5_3C96, -1, 50);

    // ld held high for 500 cycles: a single transfer.
    r0 = rises_tot; a0 = att_low_tot;
    Data_Register = 32'h0012_3456;
    DelAttSelect  = 2'b01;
    @(posedge clk); #1 ld = 1'b1;
    repeat (500) @(posedge clk);
    #1 ld = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("ld_held_rises", 32'(rises_tot - r0), NB);
    chk("ld_held_cs", 32'(att_low_tot - a0), (2 * NB + 1) * CD);

    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      run_xfer($sformatf("rand%0d", i), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, w, -1, -1);
    end

    // Reset during bit 10: abort immediately, then a clean transfer.
    r0 = rises_tot;
    Data_Register = 32'h00C3_5AA5;
    DelAttSelect  = 2'b01;
    pulse_ld(c0);
    n = 0;
    while (rises_tot - r0 < 11 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_reset_reach_bit10", 32'(n < 400), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_outputs", {28'd0, DataBit, SPI_clk, Att_CS, Del_CS}, 32'h3);
    r0 = rises_tot;
    repeat (5) @(negedge clk);
    chk("mid_reset_no_rises", 32'(rises_tot - r0), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_xfer("after_reset", 2'b10, 32'h0071_8E29, -1, -1);
    run_xfer("after_reset_att", 2'b01, $urandom, -1, -1);

    chk("data_moves_on_fall_only", 32'(viol_tot), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
